// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one weight-stationary systolic tile.
// A job has three phases: weight load (LOAD), activation streaming (FEED) and
// pipeline drain (DRAIN).
// Optional build macro SEQ_PERF_CNT_EN adds a 32-bit busy-cycle counter output, cycle_cnt.
module systolic_seq_ctrl #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned VEC_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [VEC_W-1:0]          num_vecs,
  output logic                      busy,
  output logic                      done,
  output logic                      w_rd_en,
  output logic [$clog2(ROWS)-1:0]   w_rd_addr,
  output logic                      load_weight,
  output logic                      a_rd_en,
  output logic [VEC_W-1:0]          a_rd_addr,
  output logic [COLS-1:0]           feed_valid,
  output logic                      res_valid,
  output logic [VEC_W-1:0]          res_idx
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]               cycle_cnt
`endif
);

  localparam int unsigned AW = $clog2(ROWS);

  typedef enum logic [1:0] {StIdle, StLoad, StFeed, StDrain} state_e;

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  nvec_q, nvec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              w_rd_en_q, w_rd_en_d;
  logic [AW-1:0]     w_rd_addr_q, w_rd_addr_d;
  logic              load_weight_q, load_weight_d;
  logic              a_rd_en_q, a_rd_en_d;
  logic [VEC_W-1:0]  a_rd_addr_q, a_rd_addr_d;
  logic [COLS-1:0]   feed_q, feed_d;
  logic [ROWS-1:0]   drain_q, drain_d;
  logic              res_valid_q, res_valid_d;
  logic [VEC_W-1:0]  res_idx_q, res_idx_d;

  // Next-state and registered-output logic of the job FSM.
  always_comb begin
    state_d     = state_q;
    nvec_d      = nvec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    w_rd_en_d   = 1'b0;
    w_rd_addr_d = w_rd_addr_q;
    a_rd_en_d   = 1'b0;
    a_rd_addr_d = a_rd_addr_q;
    res_idx_d   = res_valid_q ? res_idx_q + VEC_W'(1) : res_idx_q;

    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          if (num_vecs != '0) begin
            state_d     = StLoad;
            nvec_d      = num_vecs;
            busy_d      = 1'b1;
            w_rd_en_d   = 1'b1;
            // Bottom row first: weights shift south through the array.
            w_rd_addr_d = AW'(ROWS - 1);
            res_idx_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (w_rd_addr_q != '0) begin
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = w_rd_addr_q - AW'(1);
        end else begin
          // Overlaps the last load_weight cycle; activation data lands a cycle later.
          state_d     = StFeed;
          a_rd_en_d   = 1'b1;
          a_rd_addr_d = '0;
        end
      end
      StFeed: begin
        if (a_rd_addr_q != nvec_q - VEC_W'(1)) begin
          a_rd_en_d   = 1'b1;
          a_rd_addr_d = a_rd_addr_q + VEC_W'(1);
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (res_valid_q && (res_idx_q == nvec_q - VEC_W'(1))) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Valid pipeline: column skew followed by the row/drain latency to the east edge.
  always_comb begin
    load_weight_d = w_rd_en_q;
    feed_d        = '0;
    drain_d       = '0;
    feed_d[0]     = a_rd_en_q;
    for (int c = 1; c < COLS; c++) begin
      feed_d[c] = feed_q[c-1];
    end
    drain_d[0] = feed_q[COLS-1];
    for (int r = 1; r < ROWS; r++) begin
      drain_d[r] = drain_q[r-1];
    end
    res_valid_d = drain_q[ROWS-1];
  end

  // State and output registers; reset aborts any job without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      nvec_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      w_rd_en_q     <= 1'b0;
      w_rd_addr_q   <= '0;
      load_weight_q <= 1'b0;
      a_rd_en_q     <= 1'b0;
      a_rd_addr_q   <= '0;
      feed_q        <= '0;
      drain_q       <= '0;
      res_valid_q   <= 1'b0;
      res_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      nvec_q        <= nvec_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      w_rd_en_q     <= w_rd_en_d;
      w_rd_addr_q   <= w_rd_addr_d;
      load_weight_q <= load_weight_d;
      a_rd_en_q     <= a_rd_en_d;
      a_rd_addr_q   <= a_rd_addr_d;
      feed_q        <= feed_d;
      drain_q       <= drain_d;
      res_valid_q   <= res_valid_d;
      res_idx_q     <= res_idx_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign w_rd_en     = w_rd_en_q;
  assign w_rd_addr   = w_rd_addr_q;
  assign load_weight = load_weight_q;
  assign a_rd_en     = a_rd_en_q;
  assign a_rd_addr   = a_rd_addr_q;
  assign feed_valid  = feed_q;
  assign res_valid   = res_valid_q;
  assign res_idx     = res_idx_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  // Busy-cycle count: cleared on job accept, frozen once busy drops.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (state_q == StIdle && start && !done_q) begin
      cycle_cnt_d = '0;
    end else if (busy_q) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  // Busy-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl (ROWS=4, COLS=4, VEC_W=8).
// The reference model predicts every output from the accepted job's start edge and
// length using the closed-form phase delays.
module tb_systolic_seq_ctrl;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int VW = 8;
  localparam int AW = 2;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          load_weight;
    logic          a_rd_en;
    logic [VW-1:0] a_rd_addr;
    logic [C-1:0]  feed_valid;
    logic          res_valid;
    logic [VW-1:0] res_idx;
  } outs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [VW-1:0] num_vecs = '0;
  logic          busy, done, w_rd_en, load_weight, a_rd_en, res_valid;
  logic [AW-1:0] w_rd_addr;
  logic [VW-1:0] a_rd_addr, res_idx;
  logic [C-1:0]  feed_valid;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]   cycle_cnt;
`endif

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.ROWS(R), .COLS(C), .VEC_W(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vecs   (num_vecs),
    .busy       (busy),
    .done       (done),
    .w_rd_en    (w_rd_en),
    .w_rd_addr  (w_rd_addr),
    .load_weight(load_weight),
    .a_rd_en    (a_rd_en),
    .a_rd_addr  (a_rd_addr),
    .feed_valid (feed_valid),
    .res_valid  (res_valid),
    .res_idx    (res_idx)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int jt = 0;
  int jn = 0;
  bit jvalid = 1'b0;
  int free_edge = 0;
  outs_t got, exp;

  // Edges from acceptance to the done pulse becoming visible.
  function automatic int lat(input int n);
    return (n == 0) ? 0 : 2 * R + C + 1 + n;
  endfunction

  // Expected outputs just after edge e, from the current job's start edge and length.
  function automatic outs_t model_outs(input int e);
    outs_t o = '0;
    int d;
    if (!jvalid) return o;
    d = e - jt;
    if (jn == 0) begin
      o.done = (d == 0);
      return o;
    end
    o.busy = (d >= 0) && (d < lat(jn));
    o.done = (d == lat(jn));
    if (d >= 0 && d < R) begin
      o.w_rd_en   = 1'b1;
      o.w_rd_addr = AW'(R - 1 - d);
    end
    o.load_weight = (d >= 1) && (d <= R);
    if (d >= R && d < R + jn) begin
      o.a_rd_en   = 1'b1;
      o.a_rd_addr = VW'(d - R);
    end
    for (int c = 0; c < C; c++) o.feed_valid[c] = (d >= R + 1 + c) && (d <= R + c + jn);
    if (d >= 2 * R + C + 1 && d < 2 * R + C + 1 + jn) begin
      o.res_valid = 1'b1;
      o.res_idx   = VW'(d - (2 * R + C + 1));
    end
    return o;
  endfunction

  // Addresses and index are only meaningful while their strobe is high.
  function automatic outs_t dut_outs();
    outs_t o;
    o.busy        = busy;
    o.done        = done;
    o.w_rd_en     = w_rd_en;
    o.w_rd_addr   = w_rd_en ? w_rd_addr : '0;
    o.load_weight = load_weight;
    o.a_rd_en     = a_rd_en;
    o.a_rd_addr   = a_rd_en ? a_rd_addr : '0;
    o.feed_valid  = feed_valid;
    o.res_valid   = res_valid;
    o.res_idx     = res_valid ? res_idx : '0;
    return o;
  endfunction

  // Drive inputs for one edge, update the model's job acceptance, settle 1 time unit.
  task automatic step(input bit s, input logic [VW-1:0] n);
    start    = s;
    num_vecs = n;
    @(posedge clk);
    cyc++;
    if (s && !rst && cyc >= free_edge) begin
      jt        = cyc;
      jn        = int'(n);
      jvalid    = 1'b1;
      free_edge = cyc + lat(jn) + 2;
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    got = dut_outs();
    checks++;
    if (got !== outs_t'(0)) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", got);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0);
      got = dut_outs();
      exp = model_outs(cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
`ifdef SEQ_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt);
    end
`endif
    #2 rst = 1'b0;
    step(1'b0, '0);
  endtask

  task automatic test_basic();
    step(1'b1, 8'd3);
    for (int i = 0; i < 22; i++) begin
      if (i > 0) step(1'b0, 8'($urandom));
      got = dut_outs();
      exp = model_outs(cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_zero();
    step(1'b1, 8'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0, '0);
      got = dut_outs();
      exp = model_outs(cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL zero_vecs cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_held_start();
    int accepted = 0;
    int last_jt = jt;
    for (int i = 0; i < 45; i++) begin
      step(i < 20, 8'd1);
      if (jt != last_jt) begin
        accepted++;
        last_jt = jt;
      end
      got = dut_outs();
      exp = model_outs(cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL held_start cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
    // 20 held cycles cover one full 16-edge accept-to-accept span plus the next accept.
    checks++;
    if (accepted != 2) begin
      errors++;
      $display("FAIL held_start_jobs got=%0d exp=2", accepted);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'd5);
    for (int i = 0; i < 5; i++) step(1'b0, '0);
    #2 rst = 1'b1;
    jvalid = 1'b0;
    free_edge = 0;
    #1;
    got = dut_outs();
    checks++;
    if (got !== outs_t'(0)) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=0", got);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0);
      got = dut_outs();
      checks++;
      if (got !== outs_t'(0)) begin
        errors++;
        $display("FAIL reset_mid_hold cyc=%0d got=%h exp=0", cyc, got);
      end
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(i == 1, 8'd2);
      got = dut_outs();
      exp = model_outs(cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_rerun cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_max();
    int nres = 0;
    int max_addr = -1;
    int done_at = -1;
    int t0;
    step(1'b1, 8'd255);
    t0 = cyc;
    for (int i = 0; i < lat(255) + 4; i++) begin
      if (i > 0) step(1'b0, 8'($urandom));
      if (res_valid) nres++;
      if (a_rd_en && int'(a_rd_addr) > max_addr) max_addr = int'(a_rd_addr);
      if (done && done_at < 0) done_at = cyc - t0;
      got = dut_outs();
      exp = model_outs(cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL max_job cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
    checks++;
    if (nres != 255 || max_addr != 254 || done_at != 2 * R + C + 1 + 255) begin
      errors++;
      $display("FAIL max_job_totals got res=%0d addr=%0d done=%0d exp res=255 addr=254 done=%0d",
               nres, max_addr, done_at, 2 * R + C + 1 + 255);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) == 0, 8'($urandom_range(0, 12)));
      got = dut_outs();
      exp = model_outs(cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
    for (int i = 0; i < 30; i++) step(1'b0, '0);
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf();
    bit seen = 1'b0;
    step(1'b1, 8'd3);
    checks++;
    if (cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_start got=%0d exp=0", cycle_cnt);
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, '0);
      seen = done;
    end
    checks++;
    if (!seen || cycle_cnt !== 32'd16) begin
      errors++;
      $display("FAIL perf_done seen=%0d got=%0d exp=16", seen, cycle_cnt);
    end
    for (int i = 0; i < 5; i++) step(1'b0, '0);
    checks++;
    if (cycle_cnt !== 32'd16) begin
      errors++;
      $display("FAIL perf_hold got=%0d exp=16", cycle_cnt);
    end
    step(1'b1, 8'd3);
    checks++;
    if (cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_restart got=%0d exp=0", cycle_cnt);
    end
    step(1'b0, '0);
    checks++;
    if (cycle_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_count got=%0d exp=1", cycle_cnt);
    end
    for (int i = 0; i < 20; i++) step(1'b0, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_held_start();
    test_reset_mid();
    test_max();
    test_random();
`ifdef SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
